// File: rtl/obuf_requantizer.sv
// -----------------------------------------------------------------------------
// obuf_requantizer
//
// Output-buffer requantizer behind the fusion MAC engine. It takes one packed
// 128-bit accumulator word per in_valid/in_ready handshake and unpacks it into
// 1, 4 or 16 signed lanes, depending on the precision mode. Each lane gets a
// round-half-up arithmetic right shift followed by saturation to int8. The
// resulting bytes stream out one lane per beat on out_valid/out_ready/out_last.
//
// Optional feature macro: REQUANT_RELU_EN
//   When defined, negative results are forced to 0 after saturation. Such a
//   lane counts as saturated only if it also clipped at +127.
//
// Ports
//   clk        in   1    clock
//   nrst       in   1    synchronous active-low reset
//   in_valid   in   1    upstream word valid
//   in_ready   out  1    high while idle (ready to accept a word)
//   in_data    in   128  packed accumulator word
//   mode       in   2    00=2bx2b (16 lanes), 01=4bx4b (4), 10=8bx8b (1), 11=drop
//   shift      in   5    right-shift amount 0..31
//   out_valid  out  1    output byte valid
//   out_ready  in   1    downstream ready
//   out_data   out  8    requantized signed byte (0 when not valid)
//   out_lane   out  4    lane index of the presented byte (0 when not valid)
//   out_last   out  1    final lane of the word (0 when not valid)
//   sat_count  out  16   lanes clipped since reset, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module obuf_requantizer #(
    parameter int LANE_W_8B = 20,
    parameter int LANE_W_4B = 12,
    parameter int LANE_W_2B = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [1:0]   mode,
    input  logic [4:0]   shift,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic [3:0]   out_lane,
    output logic         out_last,
    output logic [15:0]  sat_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        state_q, state_d;
    logic [127:0]  data_q, data_d;
    logic [1:0]    mode_q, mode_d;
    logic [4:0]    shift_q, shift_d;
    logic [3:0]    lane_idx_q, lane_idx_d;
    logic [15:0]   sat_count_q, sat_count_d;

    // Static lane views of the buffered word.
    logic signed [LANE_W_4B-1:0] lanes_4b [4];
    logic signed [LANE_W_2B-1:0] lanes_2b [16];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lanes_4b
            assign lanes_4b[gi] = data_q[gi*LANE_W_4B +: LANE_W_4B];
        end
        for (gi = 0; gi < 16; gi++) begin : g_lanes_2b
            assign lanes_2b[gi] = data_q[gi*LANE_W_2B +: LANE_W_2B];
        end
    endgenerate

    // Lane selection, sign-extended to 22 bits.
    logic signed [21:0] lane_v;
    logic [3:0]         lanes_m1;
    logic               lane_last;

    always_comb begin
        lane_v   = '0;
        lanes_m1 = '0;
        case (mode_q)
            2'b10: begin
                lane_v   = 22'(signed'(data_q[LANE_W_8B-1:0]));
                lanes_m1 = 4'd0;
            end
            2'b01: begin
                lane_v   = 22'(lanes_4b[lane_idx_q[1:0]]);
                lanes_m1 = 4'd3;
            end
            2'b00: begin
                lane_v   = 22'(lanes_2b[lane_idx_q]);
                lanes_m1 = 4'd15;
            end
            default: begin
                lane_v   = '0;
                lanes_m1 = '0;
            end
        endcase
    end

    assign lane_last = (lane_idx_q == lanes_m1);

    // Rounding shift done in 40 bits so the rounding constant (up to 2^30)
    // can never overflow; large shifts then naturally collapse to 0 or -1.
    logic        [39:0] rnd;
    logic signed [39:0] sum;
    logic signed [39:0] shifted;
    logic        [7:0]  res_byte;
    logic               res_clip;

    always_comb begin
        rnd = '0;
        if (shift_q != 5'd0) begin
            rnd[shift_q - 5'd1] = 1'b1;
        end
        sum      = 40'(lane_v) + $signed(rnd);
        shifted  = sum >>> shift_q;
        res_byte = shifted[7:0];
        res_clip = 1'b0;
        if (shifted > 40'sd127) begin
            res_byte = 8'h7F;
            res_clip = 1'b1;
        end else if (shifted < -40'sd128) begin
            res_byte = 8'h80;
            res_clip = 1'b1;
        end
`ifdef REQUANT_RELU_EN
        // Negative results clamp to zero and are not counted as clipped.
        if (shifted < 40'sd0) begin
            res_byte = 8'h00;
            res_clip = 1'b0;
        end
`endif
    end

    logic out_hs;
    assign out_hs = (state_q == EMIT) && out_ready;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        lane_idx_d  = lane_idx_q;
        sat_count_d = sat_count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    mode_d     = mode;
                    shift_d    = shift;
                    lane_idx_d = '0;
                    // Mode 11 words are accepted and silently dropped.
                    if (mode != 2'b11) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_hs) begin
                    if (res_clip && (sat_count_q != 16'hFFFF)) begin
                        sat_count_d = sat_count_q + 16'd1;
                    end
                    if (lane_last) begin
                        state_d    = IDLE;
                        lane_idx_d = '0;
                    end else begin
                        lane_idx_d = lane_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            mode_q      <= '0;
            shift_q     <= '0;
            lane_idx_q  <= '0;
            sat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            lane_idx_q  <= lane_idx_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_data  = out_valid ? res_byte   : 8'h00;
    assign out_lane  = out_valid ? lane_idx_q : 4'd0;
    assign out_last  = out_valid ? lane_last  : 1'b0;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_obuf_requantizer.sv
module tb_obuf_requantizer;

    logic         clk;
    logic         nrst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   mode;
    logic [4:0]   shift;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_lane;
    logic         out_last;
    logic [15:0]  sat_count;

    obuf_requantizer dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_sat = '0;

    // Expected bytes (signed, no ReLU) and clip flags per lane for run_word.
    logic [7:0] exp_q    [16];
    bit         exp_clip [16];

    typedef struct {
        logic [19:0] lane;
        logic [4:0]  sh;
        logic [7:0]  exp;
        bit          clip;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies the optional ReLU to a signed expectation.
    task automatic adjust(input logic [7:0] e_in, input bit c_in,
                          output logic [7:0] e_out, output bit c_out);
        e_out = e_in;
        c_out = c_in;
`ifdef REQUANT_RELU_EN
        if (e_in[7]) begin
            e_out = 8'h00;
            c_out = 1'b0;
        end
`endif
    endtask

    // Sends one word and drains n lanes with out_ready high, checking each beat
    // against exp_q/exp_clip. Inputs are scrambled after accept to prove latching.
    task automatic run_word(input logic [127:0] d, input logic [1:0] m,
                            input logic [4:0] s, input int n);
        logic [7:0] e;
        bit c;
        in_data   = d;
        mode      = m;
        shift     = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        mode     = m ^ 2'b01;
        shift    = ~s;
        for (int i = 0; i < n; i++) begin
            adjust(exp_q[i], exp_clip[i], e, c);
            chk("in_ready_emit", 32'(in_ready), 32'd0);
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_data", 32'(out_data), 32'(e));
            chk("out_lane", 32'(out_lane), 32'(i));
            chk("out_last", 32'(out_last), 32'(i == n - 1));
            if (c) exp_sat = exp_sat + 16'd1;
            tick();
        end
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("out_valid_after", 32'(out_valid), 32'd0);
        chk("out_data_idle", 32'(out_data), 32'd0);
        chk("out_lane_idle", 32'(out_lane), 32'd0);
        chk("out_last_idle", 32'(out_last), 32'd0);
        chk("sat_count", 32'(sat_count), 32'(exp_sat));
        $display("word mode=%0d shift=%0d lanes=%0d sat_count=%0d", m, s, n, sat_count);
    endtask

    initial begin
        logic [127:0] d;
        logic [7:0] e;
        bit c;
        int lane;
        int cyc;

        vecs[0]  = '{20'd400,   5'd2,  8'h64, 1'b0};
        vecs[1]  = '{20'd0,     5'd0,  8'h00, 1'b0};
        vecs[2]  = '{20'd127,   5'd0,  8'h7F, 1'b0};
        vecs[3]  = '{20'd128,   5'd0,  8'h7F, 1'b1};
        vecs[4]  = '{20'hFFF80, 5'd0,  8'h80, 1'b0};
        vecs[5]  = '{20'hFFF7F, 5'd0,  8'h80, 1'b1};
        vecs[6]  = '{20'h7FFFF, 5'd31, 8'h00, 1'b0};
        vecs[7]  = '{20'h80000, 5'd31, 8'h00, 1'b0};
        vecs[8]  = '{20'h80000, 5'd19, 8'hFF, 1'b0};
        vecs[9]  = '{20'h7FFFF, 5'd12, 8'h7F, 1'b1};
        vecs[10] = '{20'd3,     5'd1,  8'h02, 1'b0};
        vecs[11] = '{20'hFFFFD, 5'd1,  8'hFF, 1'b0};
        vecs[12] = '{20'hFFFFB, 5'd1,  8'hFE, 1'b0};

        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 2'b00;
        shift     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_lane", 32'(out_lane), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        nrst = 1'b1;
        tick();

        // Single-lane 8bx8b vectors; upper bits carry junk that must be ignored.
        for (int v = 0; v < 13; v++) begin
            d = {108'hA5A5_5A5A_DEAD_BEEF_1234_567, vecs[v].lane};
            exp_q[0]    = vecs[v].exp;
            exp_clip[0] = vecs[v].clip;
            run_word(d, 2'b10, vecs[v].sh, 1);
        end

        // 4bx4b: {2047, -2048, 5, -3}, shift 0.
        d = {80'hFFFF_0000_1234_ABCD_5555, 12'hFFD, 12'h005, 12'h800, 12'h7FF};
        exp_q[0] = 8'h7F; exp_clip[0] = 1'b1;
        exp_q[1] = 8'h80; exp_clip[1] = 1'b1;
        exp_q[2] = 8'h05; exp_clip[2] = 1'b0;
        exp_q[3] = 8'hFD; exp_clip[3] = 1'b0;
        run_word(d, 2'b01, 5'd0, 4);

        // Rounding in 2bx2b, shift 2: -6 -> FF, 6 -> 02, 2 -> 01, zeros elsewhere.
        d = '0;
        d[7:0] = 8'hFA; d[15:8] = 8'h06; d[23:16] = 8'h02;
        for (int i = 0; i < 16; i++) begin
            exp_q[i] = 8'h00; exp_clip[i] = 1'b0;
        end
        exp_q[0] = 8'hFF; exp_q[1] = 8'h02; exp_q[2] = 8'h01;
        run_word(d, 2'b00, 5'd2, 16);

        // 2bx2b lanes 0..15 with out_ready toggling; stalls must hold the beat.
        d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
        in_data = d; mode = 2'b00; shift = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lane = 0;
        cyc  = 0;
        while (lane < 16 && cyc < 100) begin
            out_ready = cyc[0];
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(lane));
            chk("stall_lane", 32'(out_lane), 32'(lane));
            chk("stall_last", 32'(out_last), 32'(lane == 15));
            tick();
            if (cyc[0]) lane++;
            cyc++;
        end
        chk("stall_done", 32'(lane), 32'd16);
        chk("stall_in_ready_after", 32'(in_ready), 32'd1);
        $display("word mode=0 shift=0 lanes=16 stalled cycles=%0d", cyc);

        // Reset after lane 5 of a 16-lane word.
        in_data = d; mode = 2'b00; shift = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("pre_rst_lane", 32'(out_lane), 32'(i));
            tick();
        end
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        exp_sat = '0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sat_count", 32'(sat_count), 32'd0);
        $display("reset mid-word: out_valid=%0d in_ready=%0d sat_count=%0d", out_valid, in_ready, sat_count);
        for (int i = 0; i < 16; i++) begin
            exp_q[i] = 8'(i); exp_clip[i] = 1'b0;
        end
        run_word(d, 2'b00, 5'd0, 16);

        // Mode 11 is swallowed; the next word is accepted on the following cycle.
        in_data = 128'h1234; mode = 2'b11; shift = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("m11_in_ready", 32'(in_ready), 32'd1);
        chk("m11_out_valid", 32'(out_valid), 32'd0);
        in_data = 128'd400; mode = 2'b10; shift = 5'd2;
        tick();
        in_valid = 1'b0;
        chk("m11_next_valid", 32'(out_valid), 32'd1);
        chk("m11_next_data", 32'(out_data), 32'h64);
        chk("m11_next_last", 32'(out_last), 32'd1);
        tick();
        chk("m11_next_in_ready", 32'(in_ready), 32'd1);
        $display("mode 11 dropped, following word out_data=64");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/obuf_requantizer.md
# obuf_requantizer

Downstream stage of the fusion MAC engine. It accepts one packed 128-bit accumulator word per valid/ready handshake, together with the precision mode that produced it. It unpacks the word into 1, 4 or 16 signed lanes, then applies a rounding arithmetic right shift and saturation to int8 on each lane. The resulting bytes stream out one lane per cycle on a valid/ready/last interface to the next layer's activation buffer.

## Interface
- `LANE_W_8B`, default 20: lane width in 8bx8b mode.
- `LANE_W_4B`, default 12: lane width in 4bx4b mode.
- `LANE_W_2B`, default 8: lane width in 2bx2b mode.
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  high exactly when state is IDLE.
- in_data  in  128  packed accumulator word.
- mode  in  2  precision of in_data: 00 = 2bx2b, 01 = 4bx4b, 10 = 8bx8b, 11 = invalid. Sampled on accept.
- shift  in  5  right-shift amount, 0..31. Sampled on accept.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream ready.
- out_data  out  8  requantized signed byte.
- out_lane  out  4  index of the lane being presented.
- out_last  out  1  high on the final lane of the word.
- sat_count  out  16  lanes clipped since reset; saturates at 16'hFFFF.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, register in_data, mode and shift; lane_idx <= 0.
  - If mode != 11, go to EMIT. If mode == 11, drop the word and stay in IDLE; no output is produced.
- EMIT:
  - out_valid = 1.
  - On each out_valid && out_ready, lane_idx advances by 1.
  - When the handshake falls on the final lane, return to IDLE.
- Lane layout:
  - mode 10: 1 lane at [19:0].
  - mode 01: 4 lanes, lane k at [12k+11:12k].
  - mode 00: 16 lanes, lane k at [8k+7:8k].
  - Bits above the last lane are ignored.
- Arithmetic, per lane:
  - Sign-extend the lane to 22 bits to give v.
  - If shift > 0, add 1 << (shift-1) (round half up).
  - Arithmetic right shift by shift. For shift ≥ 21 the result is 0 or -1.
  - Saturate to [-128, 127].
- sat_count increments once for each emitted lane (at its handshake) where clipping occurred.
- out_lane = lane_idx and out_last = (lane_idx == lanes-1), both qualified by out_valid; they are 0 otherwise.
- out_data is 0 whenever out_valid = 0.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, out_lane 0, out_last 0, sat_count 0, and the internal buffer 0.
- Latency: a word accepted at edge N presents lane 0 with out_valid high in the cycle after edge N.
- Throughput: one byte per cycle while out_ready is held high. A word of L lanes occupies L+1 cycles: L beats plus one cycle for the IDLE accept.
- in_ready is low for the whole of EMIT. There is no bypass: the next word is accepted no earlier than the cycle after the last-lane handshake.
- Stall: while out_valid && !out_ready, out_data, out_lane and out_last hold stable and lane_idx does not advance.
- Input changes during EMIT have no effect, because mode and shift are latched.
- Reset mid-EMIT: at the next edge the block returns to IDLE, the word is discarded, and sat_count clears.

## Configuration
- `REQUANT_RELU_EN`:
  - Defined: after saturation, negative results become 0. Such a lane does not count as saturated unless it also clipped at 127.
  - Undefined: output is signed and unchanged.

## Test plan
- mode 10, in_data[19:0] = 400, shift = 2 -> a single beat with out_data = 8'h64, out_lane = 0, out_last = 1; in_ready returns high the cycle after the handshake.
- mode 01, lanes {2047, -2048, 5, -3}, shift = 0, out_ready held high -> four consecutive beats 7F, 80, 05, FD; sat_count = 2; out_last only on lane 3.
- mode 00, 16 lanes with values 0..15, shift = 0, out_ready toggling 1/0 -> 16 beats in lane order 00..0F; data and lane stay stable during stalls; in_ready stays low until the cycle after lane 15.
- Rounding, mode 00, shift = 2: lane 0 = -6 -> FF; lane 1 = 6 -> 02; lane 2 = 2 -> 01. With `REQUANT_RELU_EN` defined, lane 0 -> 00.
- Assert nrst after lane 5 of a 16-lane word -> the next cycle shows out_valid 0, in_ready 1, sat_count 0. A fresh word then starts at lane 0.
- mode 11 word offered -> accepted with in_ready high, no out_valid ever asserted; in_ready stays high and the next word is accepted on the following cycle.
